// File: rtl/ml_stage2_result_serializer_pkg.sv
// Shared field layout, packet lengths and FSM encoding for the stage-2 result
// serializer and its argmax helper.
package ml_stage2_result_serializer_pkg;
  localparam int SCORE_W    = 9;
  localparam int N_SCORES   = 5;
  localparam int FEAT_W     = 8;
  localparam int N_FEATS    = 10;
  localparam int OUT_W      = 16;
  localparam int FEAT_BASE  = SCORE_W * N_SCORES;
  localparam int IN_W       = FEAT_BASE + FEAT_W * N_FEATS;
  localparam int IDX_W      = 3;
  localparam int CNT_W      = 4;
  localparam int PKT_FULL   = 1 + N_SCORES + N_FEATS / 2;
  localparam int PKT_SCORES = 1 + N_SCORES;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  function automatic logic [SCORE_W-1:0] score_at(input logic [IN_W-1:0] v, input int i);
    return v[SCORE_W*i +: SCORE_W];
  endfunction

  // Two adjacent features packed high:low into one output word.
  function automatic logic [2*FEAT_W-1:0] feat_pair(input logic [IN_W-1:0] v, input int m);
    return v[FEAT_BASE + 2*FEAT_W*m +: 2*FEAT_W];
  endfunction
endpackage

// File: rtl/ml_stage2_argmax.sv
// Sequential argmax: start loads score0, then one score per score_valid cycle;
// strict compare so ties keep the lowest index. done rises after the last score.
module ml_stage2_argmax
  import ml_stage2_result_serializer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  output logic [SCORE_W-1:0] best,
  output logic [IDX_W-1:0]   idx,
  output logic               done
);
  logic [IDX_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      best <= '0;
      idx  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (start) begin
      best <= score;
      idx  <= '0;
      cnt  <= IDX_W'(1);
      done <= 1'b0;
    end else if (score_valid && !done) begin
      if (score > best) begin
        best <= score;
        idx  <= cnt;
      end
      cnt <= cnt + IDX_W'(1);
      if (cnt == IDX_W'(N_SCORES - 1)) done <= 1'b1;
    end
  end
endmodule

// File: rtl/ml_stage2_result_serializer.sv
// Captures one model_out vector, finds the best class, then streams the
// header/score/feature packet out over a valid/ready word interface.
module ml_stage2_result_serializer
  import ml_stage2_result_serializer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              cfg_scores_only,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       pkt_count
);
  localparam logic [CNT_W-1:0] LAST_FULL   = CNT_W'(PKT_FULL - 1);
  localparam logic [CNT_W-1:0] LAST_SCORES = CNT_W'(PKT_SCORES - 1);

  state_e             state, state_nx;
  logic [IN_W-1:0]    cap_q;
  logic               scores_only_q;
  logic [CNT_W-1:0]   word_cnt;
  logic [SCORE_W-1:0] best;
  logic [IDX_W-1:0]   idx;
  logic               am_done, am_valid, cap, fire, last_word;
  logic [SCORE_W-1:0] am_score;
  logic [OUT_W-1:0]   word;

  assign cap       = in_valid & in_ready;
  assign fire      = out_valid & out_ready;
  assign last_word = (word_cnt == (scores_only_q ? LAST_SCORES : LAST_FULL));
  assign am_valid  = (state == ST_SCAN) & ~am_done;

  // word_cnt doubles as the score pointer while scanning, then as the word index.
  always_comb begin
    int k;
    k        = int'(word_cnt);
    am_score = cap ? score_at(in_data, 0) : score_at(cap_q, k);
  end

  ml_stage2_argmax u_argmax (
    .clk         (clk),
    .rst         (rst),
    .start       (cap),
    .score       (am_score),
    .score_valid (am_valid),
    .best        (best),
    .idx         (idx),
    .done        (am_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cap_q         <= '0;
      scores_only_q <= 1'b0;
      word_cnt      <= '0;
      pkt_count     <= '0;
    end else begin
      state <= state_nx;
      if (cap) begin
        cap_q         <= in_data;
        scores_only_q <= cfg_scores_only;
        word_cnt      <= CNT_W'(1);
      end else if (state == ST_SCAN) begin
        word_cnt <= am_done ? '0 : word_cnt + CNT_W'(1);
      end else if (fire) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
      if (fire && last_word) pkt_count <= pkt_count + 16'd1;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ST_SCAN;
      end
      ST_SCAN: if (am_done) state_nx = ST_SEND;
      ST_SEND: begin
        out_valid = 1'b1;
        if (out_ready && last_word) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    int k;
    k    = int'(word_cnt);
    word = '0;
    if (k == 0)
      word[SCORE_W+IDX_W-1:0] = {idx, best};
    else if (k <= N_SCORES)
      word[SCORE_W-1:0] = score_at(cap_q, k - 1);
    else
      word[2*FEAT_W-1:0] = feat_pair(cap_q, k - N_SCORES - 1);
  end

  assign out_data = out_valid ? word : '0;
  assign out_last = out_valid & last_word;
  assign busy     = (state != ST_IDLE);
endmodule
